// File: rtl/store_narrow.sv
// -----------------------------------------------------------------------------
// store_narrow
//   Store-path narrowing unit between the execute stage and the data-memory
//   port. A 32-bit register value is narrowed to the addressed byte lanes
//   (sb/sh/sw). The unit issues one write at a time and then waits for
//   mem_ack. Requests that fail a check, and writes whose ack never arrives,
//   end with a one-cycle err pulse carrying a reason code.
//
//   Handshake: a request transfers on a rising edge where
//   req_valid && req_ready. The unit takes only one store at a time, and
//   req_ready is high only in IDLE. mem_wr_en stays high, with
//   addr/wdata/be held stable, until an edge samples mem_ack high.
//
//   Optional feature (macro STORE_NARROW_RANGE_CHECK_EN): a byte or half
//   store is rejected with code 100 unless the value survives
//   narrow-then-sign-extend unchanged. When the macro is undefined, the
//   upper bits are truncated silently.
//
//   Ports
//     clk, rst      clock (rising edge), asynchronous active-high reset
//     req_*         store request: valid/ready, byte address, data, size
//                   (00 byte, 01 half, 10 word, 11 illegal)
//     mem_*         word-aligned write: strobe, address, lane-replicated
//                   data, byte enables, and the ack input
//     done          one-cycle pulse: store completed
//     err/err_code  one-cycle pulse plus reason: 001 misaligned,
//                   010 illegal size, 011 timeout, 100 range overflow
//     dbg_state_o   current FSM state (0 IDLE, 1 WRITE, 2 RESP, 3 ERR)
// -----------------------------------------------------------------------------
module store_narrow #(
   parameter int ADDR_W  = 32,
   parameter int TIMEOUT = 15
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [31:0]       req_data,
   input  logic [1:0]        req_size,
   output logic              mem_wr_en,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   output logic [3:0]        mem_be,
   input  logic              mem_ack,
   output logic              done,
   output logic              err,
   output logic [2:0]        err_code,
   output logic [1:0]        dbg_state_o
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_WRITE = 2'd1,
      S_RESP  = 2'd2,
      S_ERR   = 2'd3
   } state_t;

   localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

   state_t      state_q;
   logic [7:0]  tmo_cnt_q;

   logic [31:0] wdata_d;
   logic [3:0]  be_d;
   logic        misaligned;
   logic        range_bad;
   logic [2:0]  chk_code_d;

   assign req_ready   = (state_q == S_IDLE) && !rst;
   assign dbg_state_o = state_q;

   // Lane narrowing: replicate the narrow value across the word so that
   // memory picks whichever lanes the byte enables select.
   always_comb begin
      wdata_d = req_data;
      be_d    = 4'b1111;
      case (req_size)
         2'b00: begin
            wdata_d = {4{req_data[7:0]}};
            be_d    = 4'b0001 << req_addr[1:0];
         end
         2'b01: begin
            wdata_d = {2{req_data[15:0]}};
            be_d    = req_addr[1] ? 4'b1100 : 4'b0011;
         end
         default: begin
            wdata_d = req_data;
            be_d    = 4'b1111;
         end
      endcase
   end

   assign misaligned = ((req_size == 2'b01) && req_addr[0]) ||
                       ((req_size == 2'b10) && (req_addr[1:0] != 2'b00));

`ifdef STORE_NARROW_RANGE_CHECK_EN
   // The upper bits must be pure sign copies of the narrow value.
   assign range_bad = ((req_size == 2'b00) && (req_data[31:8]  != {24{req_data[7]}})) ||
                      ((req_size == 2'b01) && (req_data[31:16] != {16{req_data[15]}}));
`else
   assign range_bad = 1'b0;
`endif

   // Check priority: illegal size, then misaligned, then range.
   always_comb begin
      chk_code_d = 3'b000;
      if (req_size == 2'b11)
         chk_code_d = 3'b010;
      else if (misaligned)
         chk_code_d = 3'b001;
      else if (range_bad)
         chk_code_d = 3'b100;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= S_IDLE;
         tmo_cnt_q <= 8'd0;
         mem_wr_en <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= 32'd0;
         mem_be    <= 4'd0;
         done      <= 1'b0;
         err       <= 1'b0;
         err_code  <= 3'b000;
      end else begin
         done     <= 1'b0;
         err      <= 1'b0;
         err_code <= 3'b000;
         case (state_q)
            S_IDLE: begin
               if (req_valid && req_ready) begin
                  tmo_cnt_q <= 8'd0;
                  if (chk_code_d != 3'b000) begin
                     state_q  <= S_ERR;
                     err      <= 1'b1;
                     err_code <= chk_code_d;
                  end else begin
                     state_q   <= S_WRITE;
                     mem_wr_en <= 1'b1;
                     mem_addr  <= {req_addr[ADDR_W-1:2], 2'b00};
                     mem_wdata <= wdata_d;
                     mem_be    <= be_d;
                  end
               end
            end
            S_WRITE: begin
               // An ack in the expiry cycle still wins over the timeout.
               if (mem_ack) begin
                  state_q   <= S_RESP;
                  mem_wr_en <= 1'b0;
                  done      <= 1'b1;
               end else if (tmo_cnt_q == TMO_LAST) begin
                  state_q   <= S_ERR;
                  mem_wr_en <= 1'b0;
                  err       <= 1'b1;
                  err_code  <= 3'b011;
               end else begin
                  tmo_cnt_q <= tmo_cnt_q + 8'd1;
               end
            end
            S_RESP:  state_q <= S_IDLE;
            default: state_q <= S_IDLE;
         endcase
      end
   end

endmodule

// File: doc/store_narrow.md
Name: store_narrow

Overview:
Store-path counterpart to the load-side immediate/half/byte sign extension. It accepts a 32-bit register value plus address and access size (sb/sh/sw) and narrows it to the addressed byte lanes. It drives a single-outstanding write to data memory with replicated lane data and byte enables, then waits for the memory acknowledge. It sits between the execute stage and the data-memory port, and reports alignment, size and timeout errors.

Parameters:
ADDR_W, 32, byte-address width.
TIMEOUT, 15, maximum WRITE cycles waiting for mem_ack before an error is raised (range 1..255).

Ports:
clk  input  1  clock, rising edge.
rst  input  1  asynchronous reset, active-high.
req_valid  input  1  store request valid.
req_ready  output  1  request accept; transfer occurs when req_valid && req_ready.
req_addr  input  ADDR_W  byte address.
req_data  input  32  register value to store.
req_size  input  2  00 byte, 01 half, 10 word, 11 illegal.
mem_wr_en  output  1  memory write strobe.
mem_addr  output  ADDR_W  word-aligned address (bits [1:0] = 0).
mem_wdata  output  32  lane-replicated write data.
mem_be  output  4  byte enables; bit i enables wdata[8i+7:8i].
mem_ack  input  1  memory write complete.
done  output  1  one-cycle pulse: store completed.
err  output  1  one-cycle pulse: store aborted.
err_code  output  3  000 none, 001 misaligned, 010 illegal size, 011 timeout, 100 range overflow.

Behaviour:
- Reset is asynchronous and active-high. While rst=1: state IDLE, timeout counter 0, and all registered outputs are 0 (mem_wr_en, mem_addr, mem_wdata, mem_be, done, err, err_code). req_ready = (state==IDLE) && !rst.
- States: IDLE, WRITE, RESP, ERR.
- IDLE, on accept: capture the request, then run checks in priority order:
  - size 11 -> ERR with code 010.
  - misaligned (half with addr[0]=1; word with addr[1:0]!=0) -> ERR with code 001.
  - range check (see Optional Feature).
  - otherwise -> WRITE.
- Narrowing on entry to WRITE:
  - byte: wdata = {4{data[7:0]}}, be = 1 << addr[1:0].
  - half: wdata = {2{data[15:0]}}, be = addr[1] ? 1100 : 0011.
  - word: wdata = data, be = 1111.
  - In all cases mem_addr = {addr[ADDR_W-1:2], 2'b00}.
- WRITE:
  - mem_wr_en=1, and addr/wdata/be are held stable until exit.
  - mem_ack sampled high -> RESP, and mem_wr_en drops on the next edge.
  - The counter increments each WRITE cycle with mem_ack low. After TIMEOUT such cycles -> ERR with code 011.
  - If mem_ack arrives in the same cycle as expiry, the ack wins (RESP).
- RESP: done=1 for one cycle, req_ready=0, then IDLE.
- ERR: err=1 and err_code valid for one cycle; no memory write is issued on check failures. Then IDLE, where err_code returns to 000.
- mem_ack outside WRITE is ignored.
- Latency: accept at edge 0, mem_wr_en high in cycle 1. With ack in cycle 1, done is high in cycle 2 and req_ready is high in cycle 3. Minimum 3 cycles per store.
- Reset mid-WRITE abandons the store: no done, no err.

Optional Feature:
Macro STORE_NARROW_RANGE_CHECK_EN.
- Defined: for byte stores, data[31:8] must all equal data[7]; for half stores, data[31:16] must all equal data[15]. This means the value must survive narrow-then-sign-extend unchanged. On failure: ERR with code 100, no write issued. Priority is below illegal-size and misaligned.
- Undefined: no check. Upper bits are silently truncated (standard MIPS sb/sh), and code 100 never occurs.

Test Plan:
- sb addr 0x1003 data 0x000000A5, ack in cycle 1 -> cycle 1: wr_en=1, addr 0x1000, be 1000, wdata 0xA5A5A5A5; done=1 in cycle 2; req_ready=1 in cycle 3.
- sh addr 0x2002 data 0x00001234, ack delayed to the 3rd WRITE cycle -> wr_en high exactly 3 cycles, be 1100, wdata 0x12341234, then one done pulse.
- sw addr 0x3001 -> err=1 with err_code 001 one cycle after accept; mem_wr_en never asserted. Then req_size=11 -> err_code 010.
- TIMEOUT=15, mem_ack held 0 -> wr_en high 15 cycles, then err=1 with code 011. Variant: ack in the 15th cycle -> done and no err.
- rst pulsed during WRITE -> all outputs 0 in the same cycle (asynchronous). After release, req_ready=1 and a new sw 0x4000 data 0xDEADBEEF completes with be 1111.
- sb data 0x00000180: with the macro -> err code 100 and no write; without the macro -> wdata 0x80808080, and the store completes.
